// File: rtl/memory_stage.sv
// Y86-64 PIPE memory stage: data memory access plus the W pipeline register.
// Optional macro ADDR_CHECK_EN enables the out-of-range address check (ADR status).
module memory_stage #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [63:0] m_valM,
  output logic [1:0]  m_stat,
  output logic [1:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  logic [63:0] r_mem [MEM_WORDS];

  logic          w_is_rd;
  logic          w_is_wr;
  logic [63:0]   w_addr;
  logic [AW-1:0] w_idx;
  logic          w_oob;
  logic          w_we;
  logic          w_unused;

  always_comb begin
    w_is_rd = (M_icode == I_MRMOVQ) || (M_icode == I_POPQ) || (M_icode == I_RET);
    w_is_wr = (M_icode == I_RMMOVQ) || (M_icode == I_PUSHQ) || (M_icode == I_CALL);
    // popq/ret read through the old stack pointer carried in valA
    w_addr  = ((M_icode == I_POPQ) || (M_icode == I_RET)) ? M_valA : M_valE;
    w_idx   = w_addr[AW-1:0];
  end

`ifdef ADDR_CHECK_EN
  assign w_oob = (w_is_rd || w_is_wr) && (w_addr[63:AW] != '0);
`else
  assign w_oob = 1'b0;
`endif

  assign w_unused = ^{M_cnd, w_addr[63:AW]};

  assign m_stat = w_oob ? STAT_ADR : M_stat;
  assign m_valM = (w_is_rd && !w_oob) ? r_mem[w_idx] : '0;

  // Any exception already sitting in W blocks all later stores.
  assign w_we = w_is_wr && (M_stat == STAT_AOK) && (m_stat == STAT_AOK) &&
                (W_stat == STAT_AOK);

  // Storage is never cleared; reset only drops a store landing in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset && w_we) begin
      r_mem[w_idx] <= M_valA;
    end
  end

  // W register control: W_stall holds every field and wins over W_bubble;
  // W_bubble alone loads a NOP; with neither asserted the stage result loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      W_stat  <= STAT_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= REG_NONE;
      W_dstM  <= REG_NONE;
    end else if (W_stall) begin
      W_stat  <= W_stat;
      W_icode <= W_icode;
      W_valE  <= W_valE;
      W_valM  <= W_valM;
      W_dstE  <= W_dstE;
      W_dstM  <= W_dstM;
    end else if (W_bubble) begin
      W_stat  <= STAT_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= REG_NONE;
      W_dstM  <= REG_NONE;
    end else begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random traffic against a
// word-array memory model and a simple W-register model.
module tb_memory_stage;

  logic        clk;
  logic        reset;
  logic [1:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;
  logic [63:0] m_valM;
  logic [1:0]  m_stat;
  logic [1:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  memory_stage dut (
    .clk(clk), .reset(reset),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .m_valM(m_valM), .m_stat(m_stat),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [63:0] mdl_mem [256];
  logic [1:0]  mw_stat;
  logic [3:0]  mw_icode;
  logic [63:0] mw_vale;
  logic [63:0] mw_valm;
  logic [3:0]  mw_dste;
  logic [3:0]  mw_dstm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_bubble();
    mw_stat = 2'd0; mw_icode = 4'd1; mw_vale = '0; mw_valm = '0;
    mw_dste = 4'd15; mw_dstm = 4'd15;
  endtask

  task automatic chk_w(input string tag);
    chk({tag, "_W_stat"},  {62'd0, W_stat},  {62'd0, mw_stat});
    chk({tag, "_W_icode"}, {60'd0, W_icode}, {60'd0, mw_icode});
    chk({tag, "_W_valE"},  W_valE,  mw_vale);
    chk({tag, "_W_valM"},  W_valM,  mw_valm);
    chk({tag, "_W_dst"},   {56'd0, W_dstE, W_dstM}, {56'd0, mw_dste, mw_dstm});
  endtask

  // One pipeline cycle: drive M, check combinational outputs, clock, check W.
  task automatic step(input string tag, input logic [3:0] ic, input logic [1:0] st,
                      input logic [63:0] ve, input logic [63:0] va,
                      input logic [3:0] de, input logic [3:0] dm,
                      input logic stl, input logic bub);
    logic        rd, wr, oob;
    logic [63:0] addr, exp_valm;
    logic [1:0]  exp_stat;
    int          idx;
    M_icode = ic; M_stat = st; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
    M_cnd = 1'($urandom_range(0, 1)); W_stall = stl; W_bubble = bub;
    rd   = (ic == 4'd5) || (ic == 4'd11) || (ic == 4'd9);
    wr   = (ic == 4'd4) || (ic == 4'd10) || (ic == 4'd8);
    addr = ((ic == 4'd11) || (ic == 4'd9)) ? va : ve;
    idx  = int'(addr % 64'd256);
`ifdef ADDR_CHECK_EN
    oob  = (rd || wr) && (addr >= 64'd256);
`else
    oob  = 1'b0;
`endif
    exp_stat = oob ? 2'd2 : st;
    exp_valm = (rd && !oob) ? mdl_mem[idx] : 64'd0;
    #2;
    chk({tag, "_m_valM"}, m_valM, exp_valm);
    chk({tag, "_m_stat"}, {62'd0, m_stat}, {62'd0, exp_stat});
    @(posedge clk);
    if (wr && st == 2'd0 && exp_stat == 2'd0 && mw_stat == 2'd0) mdl_mem[idx] = va;
    if (stl) begin
      // hold
    end else if (bub) begin
      mdl_bubble();
    end else begin
      mw_stat = exp_stat; mw_icode = ic; mw_vale = ve; mw_valm = exp_valm;
      mw_dste = de; mw_dstm = dm;
    end
    #1;
    chk_w(tag);
  endtask

  task automatic rd_word(input string tag, input int a);
    step(tag, 4'd5, 2'd0, 64'(a), 64'd0, 4'd15, 4'd1, 1'b0, 1'b0);
  endtask

  logic [63:0] saved;
  logic [3:0]  ric;
  logic [63:0] raddr;
  logic [3:0]  ops [9];

  initial begin
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd4; ops[3] = 4'd5; ops[4] = 4'd8;
    ops[5] = 4'd9; ops[6] = 4'd10; ops[7] = 4'd11; ops[8] = 4'd6;
    reset = 1'b1; M_stat = '0; M_icode = 4'd1; M_cnd = 1'b0; M_valE = '0; M_valA = '0;
    M_dstE = 4'd15; M_dstM = 4'd15; W_stall = 1'b0; W_bubble = 1'b0;
    mdl_bubble();
    repeat (2) @(posedge clk);
    #1;
    chk_w("reset");
    reset = 1'b0;

    // fill memory with known random contents
    for (int i = 0; i < 256; i++)
      step("fill", 4'd4, 2'd0, 64'(i), {$urandom, $urandom}, 4'd15, 4'd15, 1'b0, 1'b0);

    // store then load
    step("t1_st", 4'd4, 2'd0, 64'd5, 64'hDEAD, 4'd15, 4'd15, 1'b0, 1'b0);
    step("t1_ld", 4'd5, 2'd0, 64'd5, 64'd0, 4'd15, 4'd2, 1'b0, 1'b0);
    chk("t1_W_valM_const", W_valM, 64'hDEAD);
    chk("t1_W_icode_const", {60'd0, W_icode}, 64'd5);

    // push then pop
    step("t2_push", 4'd10, 2'd0, 64'h7F, 64'd42, 4'd4, 4'd15, 1'b0, 1'b0);
    step("t2_pop", 4'd11, 2'd0, 64'h80, 64'h7F, 4'd4, 4'd3, 1'b0, 1'b0);
    chk("t2_W_valM_const", W_valM, 64'd42);
    chk("t2_W_valE_const", W_valE, 64'h80);
    chk("t2_W_dstM_const", {60'd0, W_dstM}, 64'd3);

    // out-of-range store aliases onto word 44 unless the check is on
    saved = mdl_mem[44];
    step("t3_st", 4'd4, 2'd0, 64'd300, 64'h1234, 4'd15, 4'd15, 1'b0, 1'b0);
`ifdef ADDR_CHECK_EN
    chk("t3_W_stat_const", {62'd0, W_stat}, 64'd2);
    step("t3_bub", 4'd1, 2'd0, 64'd0, 64'd0, 4'd15, 4'd15, 1'b0, 1'b1);
    rd_word("t3_rd", 44);
    chk("t3_mem44_const", W_valM, saved);
`else
    chk("t3_W_stat_const", {62'd0, W_stat}, 64'd0);
    rd_word("t3_rd", 44);
    chk("t3_mem44_const", W_valM, 64'h1234);
`endif

    // stall / bubble control
    step("t4_ld", 4'd6, 2'd0, 64'h55, 64'd0, 4'd7, 4'd15, 1'b0, 1'b0);
    step("t4_stall1", 4'd3, 2'd0, 64'h66, 64'd0, 4'd8, 4'd15, 1'b1, 1'b0);
    step("t4_stall2", 4'd3, 2'd0, 64'h77, 64'd0, 4'd9, 4'd15, 1'b1, 1'b0);
    step("t4_both", 4'd3, 2'd0, 64'h88, 64'd0, 4'd9, 4'd15, 1'b1, 1'b1);
    chk("t4_held_valE_const", W_valE, 64'h55);
    step("t4_bub", 4'd3, 2'd0, 64'h99, 64'd0, 4'd9, 4'd9, 1'b0, 1'b1);
    chk("t4_bub_icode_const", {60'd0, W_icode}, 64'd1);
    chk("t4_bub_dst_const", {56'd0, W_dstE, W_dstM}, 64'hFF);

    // HLT in W blocks a following push
    saved = mdl_mem[20];
    step("t5_hlt", 4'd0, 2'd1, 64'd0, 64'd0, 4'd15, 4'd15, 1'b0, 1'b0);
    step("t5_push", 4'd10, 2'd0, 64'd20, 64'hBEEF, 4'd15, 4'd15, 1'b0, 1'b0);
    rd_word("t5_rd", 20);
    chk("t5_mem20_const", W_valM, saved);

    // asynchronous reset between edges drops the concurrent store
    saved = mdl_mem[33];
    M_icode = 4'd4; M_stat = 2'd0; M_valE = 64'd33; M_valA = 64'hCAFE;
    W_stall = 1'b0; W_bubble = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    mdl_bubble();
    chk_w("t6_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_w("t6_held");
    rd_word("t6_rd", 33);
    chk("t6_mem33_const", W_valM, saved);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ric = ops[$urandom_range(0, 8)];
      raddr = ($urandom_range(0, 9) == 0) ? 64'($urandom_range(256, 2000))
                                          : 64'($urandom_range(0, 255));
      step("rand", ric,
           ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
           ((ric == 4'd9) || (ric == 4'd11)) ? raddr + 64'd1 : raddr,
           ((ric == 4'd9) || (ric == 4'd11)) ? raddr : {$urandom, $urandom},
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
